regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
// Parametrised multi-read-port register file with write-through bypass, hardwired zero
// register and a per-register pending-write scoreboard. Sits between decode (issue/read)
// and writeback in the pipelined core. Replaces the fixed 32x32 two-read-port file.
// PARAMETERS
// XLEN     32  data width in bits
// NREGS    32  number of registers; power of 2, >=2
// AW       $clog2(NREGS)  address width (derived, do not override)
// NRD      2   number of read ports, 1..4
// BYPASS   1   1: same-cycle writeback data forwarded to reads; 0: reads see array only
// ZERO_REG 1   1: register 0 reads 0, ignores writes, never pending; 0: ordinary register
// PORTS
// CLK       in   1          clock, all state updates on posedge
// reset     in   1          synchronous, active-high
// rd_addr   in   NRD*AW     read addresses, port k at [k*AW +: AW]
// rd_data   out  NRD*XLEN   read data, port k at [k*XLEN +: XLEN]; combinational
// rd_busy   out  NRD        port k register has an outstanding pending write
// wr_en     in   1          writeback strobe
// wr_addr   in   AW         writeback destination
// wr_data   in   XLEN       writeback data
// iss_en    in   1          issue request: mark iss_addr pending
// iss_addr  in   AW         destination of issuing instruction
// iss_ok    out  1          issue accepted this cycle (combinational)
// pend_cnt  out  AW+1       number of registers currently pending
// BEHAVIOUR
// - Reset: reset and CLK are as decided above (clock CLK; reset synchronous, active-high).
//   On a posedge with reset=1 all NREGS registers <= 0 (full loop to NREGS, not XLEN),
//   all pending bits <= 0, pend_cnt <= 0. Reset wins over wr_en/iss_en in the same cycle.
//   After reset: rd_data = 0 on every port, rd_busy = 0, pend_cnt = 0.
// - Write: posedge with wr_en=1 -> rf[wr_addr] <= wr_data; pend[wr_addr] <= 0.
//   If ZERO_REG && wr_addr==0: no state change.
// - Read: rd_data[k] = rf[rd_addr[k]] combinationally (0 latency).
//   BYPASS=1 and wr_en && wr_addr==rd_addr[k] (and not zero reg) -> rd_data[k] = wr_data.
//   ZERO_REG && rd_addr[k]==0 -> rd_data[k] = 0 always (overrides bypass).
// - rd_busy[k] = pend[rd_addr[k]] & ~(BYPASS & wr_en & wr_addr==rd_addr[k]);
//   with BYPASS=0 the clearing write becomes visible to busy next cycle.
// - Issue: iss_ok = iss_en & ~pend[iss_addr]; a clearing write to iss_addr in the same
//   cycle does NOT free it (iss_ok=0). Accepted issue -> pend[iss_addr] <= 1 at posedge.
//   ZERO_REG && iss_addr==0: iss_ok = iss_en, no pending bit set, pend_cnt unchanged.
// - Simultaneous wr_en and accepted iss_en: different addresses -> both applied.
//   Same address cannot be accepted (pending rule). Write to non-pending reg: data written,
//   pend unchanged.
// - pend_cnt: +1 on accepted non-zero issue, -1 on write clearing a set bit, net 0 if both;
//   never wraps (max NREGS, or NREGS-1 with ZERO_REG).
// - No other state; reset mid-operation discards all pending and data immediately.
// TESTING
// 1 reset 1 cycle, prior rf garbage -> all ports read 0 for addr 0..NREGS-1, pend_cnt=0.
// 2 wr x5=0xDEADBEEF, read x5 same cycle -> rd_data=0xDEADBEEF (BYPASS=1), array next cycle.
// 3 wr x0=0x1234, iss x0 -> x0 reads 0, iss_ok=1, pend_cnt=0, rd_busy=0 for x0.
// 4 iss x7 -> iss_ok=1, next cycle rd_busy=1, pend_cnt=1; iss x7 again -> iss_ok=0;
//   wr x7=0x55 -> same cycle rd_busy=0 rd_data=0x55, next cycle pend_cnt=0.
// 5 iss x3 and wr x9 same cycle (x9 pending) -> pend_cnt unchanged, x3 busy, x9 free.
// 6 NRD=4, XLEN=16, NREGS=16: all 4 ports read distinct regs correctly; reset asserted
//   with wr_en=1 and iss_en=1 -> rf and pend all zero next cycle.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-through bypass, optional hardwired zero
// register and a per-register pending-write scoreboard feeding issue control.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_ok,
    output logic [AW:0]         pend_cnt
);

    logic [XLEN-1:0]  rf_q [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;

    logic             wr_act;
    logic             wr_clr;
    logic             iss_zero;
    logic             iss_set;
    logic [AW-1:0]    rd_idx [NRD];

    // Writes to a hardwired zero register are dropped entirely.
    always_comb begin
        wr_act   = wr_en & ~((ZERO_REG != 0) && (wr_addr == '0));
        wr_clr   = wr_act & pend_q[wr_addr];
        iss_zero = (ZERO_REG != 0) && (iss_addr == '0);
        iss_ok   = iss_en & (iss_zero | ~pend_q[iss_addr]);
        iss_set  = iss_ok & ~iss_zero;
    end

    // Clear is applied before set so an issue to a non-pending register that is
    // also being written this cycle still ends up pending.
    always_comb begin
        pend_d = pend_q;
        if (wr_act) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (iss_set) begin
            pend_d[iss_addr] = 1'b1;
        end
        cnt_d = cnt_q + (AW+1)'(iss_set) - (AW+1)'(wr_clr);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_act) begin
                rf_q[wr_addr] <= wr_data;
            end
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NRD; k++) begin
            rd_idx[k] = rd_addr[k*AW +: AW];
        end
    end

    // Zero-register override takes priority over the bypass path.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            if ((ZERO_REG != 0) && (rd_idx[k] == '0)) begin
                rd_data[k*XLEN +: XLEN] = '0;
            end else if ((BYPASS != 0) && wr_act && (wr_addr == rd_idx[k])) begin
                rd_data[k*XLEN +: XLEN] = wr_data;
            end else begin
                rd_data[k*XLEN +: XLEN] = rf_q[rd_idx[k]];
            end
            rd_busy[k] = pend_q[rd_idx[k]]
                       & ~((BYPASS != 0) && wr_en && (wr_addr == rd_idx[k]));
        end
    end

    assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 32x32/2-port instance plus a 16x16/4-port one.
module tb_regfile_sb;

    logic        CLK;
    logic        reset;

    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        iss_ok;
    logic [5:0]  pend_cnt;

    logic [15:0] rd_addr4;
    logic [63:0] rd_data4;
    logic [3:0]  rd_busy4;
    logic        wr_en4;
    logic [3:0]  wr_addr4;
    logic [15:0] wr_data4;
    logic        iss_en4;
    logic [3:0]  iss_addr4;
    logic        iss_ok4;
    logic [4:0]  pend_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    regfile_sb u_dut (
        .CLK      (CLK),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .iss_ok   (iss_ok),
        .pend_cnt (pend_cnt)
    );

    regfile_sb #(
        .XLEN  (16),
        .NREGS (16),
        .NRD   (4)
    ) u_dut4 (
        .CLK      (CLK),
        .reset    (reset),
        .rd_addr  (rd_addr4),
        .rd_data  (rd_data4),
        .rd_busy  (rd_busy4),
        .wr_en    (wr_en4),
        .wr_addr  (wr_addr4),
        .wr_data  (wr_data4),
        .iss_en   (iss_en4),
        .iss_addr (iss_addr4),
        .iss_ok   (iss_ok4),
        .pend_cnt (pend_cnt4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        rd_addr4 = '0;
        wr_en4   = 1'b0;
        wr_addr4 = '0;
        wr_data4 = '0;
        iss_en4  = 1'b0;
        iss_addr4 = '0;
        tick();
        tick();
        reset = 1'b0;

        // 1: fill with garbage, leave x2 pending, then reset
        wr_en = 1'b1;
        for (int i = 1; i < 32; i++) begin
            wr_addr = 5'(i);
            wr_data = 32'h01010101 * i;
            tick();
        end
        wr_en    = 1'b0;
        iss_en   = 1'b1;
        iss_addr = 5'd2;
        tick();
        iss_en   = 1'b0;
        rd_addr  = {5'd2, 5'd5};
        #1;
        chk("pre_rst_x5", rd_data[31:0], 64'h05050505);
        chk("pre_rst_busy_x2", rd_busy[1], 1'b1);
        chk("pre_rst_cnt", pend_cnt, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            chk("rst_p0", rd_data[31:0], 0);
            chk("rst_p1", rd_data[63:32], 0);
            chk("rst_busy", rd_busy, 0);
        end
        chk("rst_cnt", pend_cnt, 0);

        // 2: bypass then array read
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hDEADBEEF;
        rd_addr = {5'd0, 5'd5};
        #1;
        chk("byp_x5", rd_data[31:0], 64'hDEADBEEF);
        chk("byp_x0_p1", rd_data[63:32], 0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("arr_x5", rd_data[31:0], 64'hDEADBEEF);

        // 3: zero register ignores write and issue
        wr_en    = 1'b1;
        wr_addr  = 5'd0;
        wr_data  = 32'h1234;
        iss_en   = 1'b1;
        iss_addr = 5'd0;
        rd_addr  = {5'd5, 5'd0};
        #1;
        chk("x0_byp", rd_data[31:0], 0);
        chk("x0_iss_ok", iss_ok, 1'b1);
        chk("x0_busy", rd_busy[0], 1'b0);
        tick();
        wr_en  = 1'b0;
        iss_en = 1'b0;
        #1;
        chk("x0_arr", rd_data[31:0], 0);
        chk("x0_cnt", pend_cnt, 0);
        chk("x0_busy2", rd_busy[0], 1'b0);

        // 4: issue x7, reissue rejected, clearing write bypasses busy and data
        iss_en   = 1'b1;
        iss_addr = 5'd7;
        rd_addr  = {5'd0, 5'd7};
        #1;
        chk("x7_iss_ok", iss_ok, 1'b1);
        tick();
        #1;
        chk("x7_busy", rd_busy[0], 1'b1);
        chk("x7_cnt", pend_cnt, 1);
        chk("x7_reiss", iss_ok, 1'b0);
        tick();
        iss_en  = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'h55;
        #1;
        chk("x7_cnt_hold", pend_cnt, 1);
        chk("x7_busy_byp", rd_busy[0], 1'b0);
        chk("x7_data_byp", rd_data[31:0], 64'h55);
        tick();
        wr_en = 1'b0;
        #1;
        chk("x7_cnt0", pend_cnt, 0);
        chk("x7_busy0", rd_busy[0], 1'b0);

        // 5: issue x3 while writing pending x9
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        tick();
        iss_addr = 5'd3;
        wr_en    = 1'b1;
        wr_addr  = 5'd9;
        wr_data  = 32'h99;
        #1;
        chk("x3_iss_ok", iss_ok, 1'b1);
        tick();
        iss_en  = 1'b0;
        wr_en   = 1'b0;
        rd_addr = {5'd9, 5'd3};
        #1;
        chk("x3x9_cnt", pend_cnt, 1);
        chk("x3x9_busy", rd_busy, 2'b01);
        chk("x9_data", rd_data[63:32], 64'h99);

        // clearing write in the same cycle does not free the issue slot
        iss_en   = 1'b1;
        iss_addr = 5'd3;
        wr_en    = 1'b1;
        wr_addr  = 5'd3;
        wr_data  = 32'h33;
        #1;
        chk("x3_iss_blocked", iss_ok, 1'b0);
        tick();
        iss_en = 1'b0;
        wr_en  = 1'b0;
        #1;
        chk("x3_cnt0", pend_cnt, 0);
        chk("x3_busy0", rd_busy, 2'b00);
        chk("x3_data", rd_data[31:0], 64'h33);

        // counter reaches NREGS-1 and x0 issue leaves it there
        iss_en = 1'b1;
        for (int i = 1; i < 32; i++) begin
            iss_addr = 5'(i);
            tick();
        end
        chk("cnt_full", pend_cnt, 31);
        iss_addr = 5'd0;
        #1;
        chk("full_x0_ok", iss_ok, 1'b1);
        tick();
        iss_en = 1'b0;
        #1;
        chk("cnt_full_x0", pend_cnt, 31);

        // 6: four-port instance
        wr_en4 = 1'b1;
        for (int i = 1; i < 16; i++) begin
            wr_addr4 = 4'(i);
            wr_data4 = 16'hA000 + 16'(i);
            tick();
        end
        wr_en4   = 1'b0;
        rd_addr4 = {4'd0, 4'd15, 4'd3, 4'd12};
        #1;
        chk("p4_0", rd_data4[15:0], 64'hA00C);
        chk("p4_1", rd_data4[31:16], 64'hA003);
        chk("p4_2", rd_data4[47:32], 64'hA00F);
        chk("p4_3", rd_data4[63:48], 0);
        wr_en4   = 1'b1;
        wr_addr4 = 4'd3;
        wr_data4 = 16'hBEEF;
        #1;
        chk("p4_byp", rd_data4[31:16], 64'hBEEF);
        wr_en4    = 1'b0;
        iss_en4   = 1'b1;
        iss_addr4 = 4'd4;
        tick();
        iss_en4 = 1'b0;
        #1;
        chk("p4_cnt1", pend_cnt4, 1);
        reset     = 1'b1;
        wr_en4    = 1'b1;
        wr_addr4  = 4'd6;
        wr_data4  = 16'h6666;
        iss_en4   = 1'b1;
        iss_addr4 = 4'd8;
        tick();
        reset   = 1'b0;
        wr_en4  = 1'b0;
        iss_en4 = 1'b0;
        for (int a = 0; a < 16; a += 4) begin
            rd_addr4 = {4'(a + 3), 4'(a + 2), 4'(a + 1), 4'(a)};
            #1;
            chk("p4_rst_data", rd_data4, 0);
            chk("p4_rst_busy", rd_busy4, 0);
        end
        chk("p4_rst_cnt", pend_cnt4, 0);
        chk("rst_cnt_main", pend_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
